// File: rtl/led_pkg.sv
// led_pkg: shared pattern-mode encodings, pattern periods and a clog2 helper
// for the LED sequencer.
package led_pkg;

    localparam logic [1:0] MODE_BOUNCE = 2'd0;
    localparam logic [1:0] MODE_ROTATE = 2'd1;
    localparam logic [1:0] MODE_BINARY = 2'd2;
    localparam logic [1:0] MODE_BAR    = 2'd3;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Number of steps in one full cycle of pattern m on n LEDs.
    function automatic int period(input logic [1:0] m, input int n);
        return (m == MODE_BOUNCE) ? 2 * n - 2 :
               (m == MODE_ROTATE) ? n :
               (m == MODE_BINARY) ? (1 << n) : n + 1;
    endfunction

endpackage

// File: rtl/led_rate_timer.sv
// led_rate_timer: free-running prescaler producing a step tick every
// 2^(DIVW-speed) cycles.
// Ports:
//   CLK   - system clock
//   RST   - synchronous reset, active-high; clears the prescaler
//   speed - current speed level, 0 = slowest
//   tick  - high for one cycle when the low (DIVW-speed) prescaler bits are all ones
module led_rate_timer
    import led_pkg::*;
#(
    parameter int DIVW   = 25,
    parameter int NSPEED = 4,
    localparam int SPW   = (NSPEED > 1) ? clog2(NSPEED) : 1
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic [SPW-1:0] speed,
    output logic           tick
);

    logic [DIVW-1:0] presc_q, presc_d;

    always_comb begin
        presc_d = presc_q + 1'b1;
        tick = 1'b1;
        // Bits above the compare window are ignored, so higher speeds tick sooner.
        for (int i = 0; i < DIVW; i++)
            if (i < DIVW - int'(speed) && !presc_q[i]) tick = 1'b0;
    end

    always_ff @(posedge CLK) presc_q <= RST ? '0 : presc_d;

endmodule

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: LED sequencer with four selectable patterns and
// power-of-two step rates, controlled by single-cycle command pulses.
// Ports:
//   CLK    - system clock
//   RST    - synchronous reset, active-high
//   UP     - pulse: speed level +1 (saturating)
//   DOWN   - pulse: speed level -1 (saturating)
//   MODE   - pulse: advance to next pattern mode, restart at step 0
//   PAUSE  - pulse: toggle paused state
//   LED    - registered LED drive, active-high
//   SPEED  - current speed level
//   MODE_O - current pattern mode
//   PAUSED - high while paused
module led_pattern_gen
    import led_pkg::*;
#(
    parameter int NLED   = 4,
    parameter int DIVW   = 25,
    parameter int NSPEED = 4,
    localparam int SPW   = (NSPEED > 1) ? clog2(NSPEED) : 1
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            UP,
    input  logic            DOWN,
    input  logic            MODE,
    input  logic            PAUSE,
    output logic [NLED-1:0] LED,
    output logic [SPW-1:0]  SPEED,
    output logic [1:0]      MODE_O,
    output logic            PAUSED
);

    logic [SPW-1:0]  speed_q, speed_d;
    logic [1:0]      mode_q, mode_d;
    logic            paused_q, paused_d;
    logic [NLED-1:0] step_q, step_d;
    logic [NLED-1:0] led_q, led_d;
    logic            tick;
    int              k;

    led_rate_timer #(.DIVW(DIVW), .NSPEED(NSPEED)) u_timer (
        .CLK  (CLK),
        .RST  (RST),
        .speed(speed_q),
        .tick (tick)
    );

    always_comb begin
        speed_d = speed_q;
        if (UP && !DOWN && int'(speed_q) < NSPEED - 1) speed_d = speed_q + 1'b1;
        else if (DOWN && !UP && speed_q != '0) speed_d = speed_q - 1'b1;
        paused_d = paused_q ^ PAUSE;
        mode_d = MODE ? mode_q + 2'd1 : mode_q;
        // Using the next paused state suppresses a tick as pause is entered
        // and accepts it as pause is released.
        step_d = step_q;
        if (MODE) step_d = '0;
        else if (tick && !paused_d)
            step_d = (int'(step_q) == period(mode_q, NLED) - 1) ? '0 : step_q + 1'b1;
        k = int'(step_q);
        for (int i = 0; i < NLED; i++)
            led_d[i] = (mode_q == MODE_BOUNCE) ? (k == i || (k >= NLED && k < 2 * NLED - 2 && k == 2 * NLED - 2 - i)) :
                       (mode_q == MODE_ROTATE) ? (k == i) :
                       (mode_q == MODE_BINARY) ? step_q[i] :
                                                 (i < k && k <= NLED);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            speed_q  <= '0;
            mode_q   <= MODE_BOUNCE;
            paused_q <= 1'b0;
            step_q   <= '0;
            led_q    <= NLED'(1);
        end else begin
            speed_q  <= speed_d;
            mode_q   <= mode_d;
            paused_q <= paused_d;
            step_q   <= step_d;
            led_q    <= led_d;
        end
    end

    assign LED    = led_q;
    assign SPEED  = speed_q;
    assign MODE_O = mode_q;
    assign PAUSED = paused_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// tb_led_pattern_gen: self-checking bench for led_pattern_gen (NLED=4, DIVW=4, NSPEED=4).
module tb_led_pattern_gen;

    localparam int NLED   = 4;
    localparam int DIVW   = 4;
    localparam int NSPEED = 4;

    logic       CLK = 1'b0;
    logic       RST = 1'b1, UP = 1'b0, DOWN = 1'b0, MODE = 1'b0, PAUSE = 1'b0;
    logic [3:0] LED;
    logic [1:0] SPEED, MODE_O;
    logic       PAUSED;

    always #5 CLK = ~CLK;

    led_pattern_gen #(.NLED(NLED), .DIVW(DIVW), .NSPEED(NSPEED)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .UP    (UP),
        .DOWN  (DOWN),
        .MODE  (MODE),
        .PAUSE (PAUSE),
        .LED   (LED),
        .SPEED (SPEED),
        .MODE_O(MODE_O),
        .PAUSED(PAUSED)
    );

    int tests = 0;
    int fails = 0;

    // Reference state: counts edges and looks patterns up in explicit tables.
    int m_speed, m_mode, m_step, m_presc, m_led;
    bit m_paused;

    function automatic int pat(input int md, input int s);
        int bounce[6] = '{1, 2, 4, 8, 4, 2};
        int bar[5]    = '{0, 1, 3, 7, 15};
        case (md)
            0:       return bounce[s];
            1:       return 1 << s;
            2:       return s;
            default: return bar[s];
        endcase
    endfunction

    function automatic int per(input int md);
        case (md)
            0:       return 6;
            1:       return 4;
            2:       return 16;
            default: return 5;
        endcase
    endfunction

    function automatic bit tick_next();
        return ((m_presc + 1) % (1 << (DIVW - m_speed))) == 0;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input bit r, input bit u, input bit d, input bit m, input bit p);
        bit tk;
        if (r) begin
            m_speed = 0; m_mode = 0; m_paused = 0; m_step = 0; m_presc = 0; m_led = 1;
        end else begin
            tk = tick_next();
            m_led = pat(m_mode, m_step);
            m_presc = (m_presc + 1) % (1 << DIVW);
            if (u && !d && m_speed < NSPEED - 1) m_speed++;
            else if (d && !u && m_speed > 0) m_speed--;
            if (p) m_paused = !m_paused;
            if (m) begin
                m_mode = (m_mode + 1) % 4;
                m_step = 0;
            end else if (tk && !m_paused) begin
                m_step = (m_step + 1) % per(m_mode);
            end
        end
    endtask

    // One clock: drive at negedge, model the edge, compare at the next negedge.
    task automatic cyc(input bit r, input bit u, input bit d, input bit m, input bit p);
        RST = r; UP = u; DOWN = d; MODE = m; PAUSE = p;
        @(posedge CLK);
        model_edge(r, u, d, m, p);
        @(negedge CLK);
        RST = 0; UP = 0; DOWN = 0; MODE = 0; PAUSE = 0;
        chk("led", int'(LED), m_led);
        chk("speed", int'(SPEED), m_speed);
        chk("mode_o", int'(MODE_O), m_mode);
        chk("paused", int'(PAUSED), int'(m_paused));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
    endtask

    task automatic wait_led(input int exp, input int bound, input string name);
        int prev;
        int n;
        prev = int'(LED);
        n = 0;
        while (int'(LED) == prev && n < bound) begin
            cyc(0, 0, 0, 0, 0);
            n++;
        end
        chk(name, int'(LED), exp);
    endtask

    typedef struct {
        bit up, down, mode, pause;
        int sp, md;
        bit pz;
    } vec_t;

    vec_t tab[20];

    initial begin
        int n;
        int frozen;
        tab = '{
            '{1, 0, 0, 0, 1, 0, 0}, '{1, 0, 0, 0, 2, 0, 0}, '{1, 0, 0, 0, 3, 0, 0},
            '{1, 0, 0, 0, 3, 0, 0}, '{1, 0, 0, 0, 3, 0, 0}, '{0, 1, 0, 0, 2, 0, 0},
            '{0, 1, 0, 0, 1, 0, 0}, '{0, 1, 0, 0, 0, 0, 0}, '{0, 1, 0, 0, 0, 0, 0},
            '{1, 1, 0, 0, 0, 0, 0}, '{1, 0, 0, 0, 1, 0, 0}, '{1, 1, 0, 0, 1, 0, 0},
            '{0, 1, 0, 0, 0, 0, 0}, '{0, 0, 1, 0, 0, 1, 0}, '{0, 0, 1, 0, 0, 2, 0},
            '{0, 0, 1, 0, 0, 3, 0}, '{0, 0, 1, 0, 0, 0, 0}, '{0, 0, 0, 1, 0, 0, 1},
            '{0, 0, 1, 0, 0, 1, 1}, '{0, 0, 0, 1, 0, 1, 0}
        };
        @(negedge CLK);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk("rst_led", int'(LED), 1);
        chk("rst_speed", int'(SPEED), 0);
        chk("rst_mode", int'(MODE_O), 0);
        chk("rst_paused", int'(PAUSED), 0);

        // First LED change lands one edge after the 16-cycle tick.
        n = 0;
        while (LED == 4'b0001 && n < 40) begin
            cyc(0, 0, 0, 0, 0);
            n++;
        end
        chk("first_change_edges", n, 17);
        chk("first_change_led", int'(LED), 2);
        idle(40 - n);

        // Register-output vectors: speed saturation, mode wrap, pause toggling.
        foreach (tab[i]) begin
            cyc(0, tab[i].up, tab[i].down, tab[i].mode, tab[i].pause);
            chk($sformatf("vec%0d_speed", i), int'(SPEED), tab[i].sp);
            chk($sformatf("vec%0d_mode", i), int'(MODE_O), tab[i].md);
            chk($sformatf("vec%0d_paused", i), int'(PAUSED), int'(tab[i].pz));
        end

        // Back to bounce, then MODE exactly while step 3 is current.
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        chk("back_to_bounce", int'(MODE_O), 0);
        n = 0;
        while (m_step != 3 && n < 200) begin
            cyc(0, 0, 0, 0, 0);
            n++;
        end
        chk("reached_step3", m_step, 3);
        cyc(0, 0, 0, 1, 0);
        chk("mode_rotate", int'(MODE_O), 1);
        cyc(0, 0, 0, 0, 0);
        chk("rotate_start", int'(LED), 1);
        wait_led(2, 40, "rotate_1");
        wait_led(4, 40, "rotate_2");
        wait_led(8, 40, "rotate_3");
        wait_led(1, 40, "rotate_wrap");

        // Binary at top speed runs through a full wrap.
        cyc(0, 1, 0, 1, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        chk("fast_speed", int'(SPEED), 3);
        idle(40);

        // Bar sequence.
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0);
        chk("bar_start", int'(LED), 0);
        wait_led(1, 10, "bar_1");
        wait_led(3, 10, "bar_2");
        wait_led(7, 10, "bar_3");
        wait_led(15, 10, "bar_4");
        wait_led(0, 10, "bar_wrap");

        // Pause on a tick cycle: no advance, then frozen for 20 cycles.
        n = 0;
        while (!tick_next() && n < 20) begin
            cyc(0, 0, 0, 0, 0);
            n++;
        end
        cyc(0, 0, 0, 0, 1);
        chk("paused_set", int'(PAUSED), 1);
        cyc(0, 0, 0, 0, 0);
        frozen = int'(LED);
        for (int i = 0; i < 20; i++) begin
            cyc(0, 0, 0, 0, 0);
            chk("frozen_led", int'(LED), frozen);
        end
        cyc(0, 0, 0, 0, 1);
        chk("paused_clear", int'(PAUSED), 0);
        idle(12);

        // Reset mid-binary with every command asserted.
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        chk("binary_mode", int'(MODE_O), 2);
        idle(9);
        cyc(1, 1, 0, 1, 1);
        chk("rst_mid_speed", int'(SPEED), 0);
        chk("rst_mid_mode", int'(MODE_O), 0);
        chk("rst_mid_paused", int'(PAUSED), 0);
        chk("rst_mid_led", int'(LED), 1);

        // Random pulse traffic against the reference.
        for (int i = 0; i < 600; i++)
            cyc($urandom_range(0, 199) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                $urandom_range(0, 24) == 0, $urandom_range(0, 19) == 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
